phase_scheduler: RTL and testbench

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

---
 rtl/tl_pkg.sv | 17 +
 rtl/phase_timer.sv | 28 ++
 rtl/phase_scheduler.sv | 105 ++++++++++
 tb/tb_phase_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and default timing for the traffic phase scheduler.
// Tick constants are dwell-minus-one in 100 ms units.
package tl_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_e;

  typedef logic [1:0] dir_t;

  localparam logic [15:0] GREEN_DEF  = 16'd299;
  localparam logic [15:0] YELLOW_DEF = 16'd29;
  localparam logic [15:0] ALLRED_DEF = 16'd19;

endpackage

// File: rtl/phase_timer.sv
// Loadable 16-bit down-counter advanced by the tick strobe.
// done fires on the tick that finds the count at zero.
module phase_timer #(
  parameter logic [15:0] RST_VAL = 16'd0
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        done
);

  logic [15:0] count;

  assign done = tick && (count == 16'd0) && !srst;

  always_ff @(posedge clk) begin
    if (srst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Four-approach green/yellow/all-red sequencer with
// round-robin skipping of approaches flagged as underused.
module phase_scheduler
  import tl_pkg::*;
#(
  parameter logic [15:0] GREEN_TICKS  = GREEN_DEF,
  parameter logic [15:0] YELLOW_TICKS = YELLOW_DEF,
  parameter logic [15:0] ALLRED_TICKS = ALLRED_DEF
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       tick,
  input  logic [3:0] ur_list,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       all_red,
  output logic [1:0] active_dir
);

  phase_e      state, state_n;
  dir_t        dir, dir_n, nxt, cand;
  logic        found;
  logic        done, load;
  logic [15:0] load_val;

  phase_timer #(
    .RST_VAL(ALLRED_TICKS)
  ) u_timer (
    .clk     (clk),
    .srst    (srst),
    .tick    (tick),
    .load    (load),
    .load_val(load_val),
    .done    (done)
  );

  // First demanding approach after dir; plain rotation if none.
  always_comb begin
    nxt   = dir + 2'd1;
    cand  = dir;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = dir + 2'(i);
      if (!found && !ur_list[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    load     = 1'b0;
    load_val = 16'd0;
    if (done) begin
      unique case (state)
        ALLRED: begin
          state_n  = GREEN;
          dir_n    = nxt;
          load     = 1'b1;
          load_val = GREEN_TICKS;
        end
        GREEN: begin
          load = 1'b1;
          if (nxt == dir) begin
            load_val = GREEN_TICKS;
          end else begin
            state_n  = YELLOW;
            load_val = YELLOW_TICKS;
          end
        end
        YELLOW: begin
          state_n  = ALLRED;
          load     = 1'b1;
          load_val = ALLRED_TICKS;
        end
        default: begin
          state_n  = ALLRED;
          load     = 1'b1;
          load_val = ALLRED_TICKS;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= ALLRED;
      dir     <= 2'd3;
      green   <= 4'b0000;
      yellow  <= 4'b0000;
      all_red <= 1'b1;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      green   <= (state_n == GREEN) ? (4'b0001 << dir_n) : 4'b0000;
      yellow  <= (state_n == YELLOW) ? (4'b0001 << dir_n) : 4'b0000;
      all_red <= (state_n == ALLRED);
    end
  end

  assign active_dir = dir;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler with short phase constants.
// Each task drives one scenario and checks expected lights inline.
module tb_phase_scheduler;

  logic       clk;
  logic       srst;
  logic       tick;
  logic [3:0] ur_list;
  logic [3:0] green;
  logic [3:0] yellow;
  logic       all_red;
  logic [1:0] active_dir;

  int checks;
  int failures;
  logic [3:0] seen;

  phase_scheduler #(
    .GREEN_TICKS (16'd4),
    .YELLOW_TICKS(16'd2),
    .ALLRED_TICKS(16'd1)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .tick      (tick),
    .ur_list   (ur_list),
    .green     (green),
    .yellow    (yellow),
    .all_red   (all_red),
    .active_dir(active_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    seen = seen | green;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    seen = 4'b0000;
  endtask

  task automatic next_green(output logic [3:0] g, output bit to);
    int n;
    n = 0;
    while (green != 4'b0000 && n < 2000) begin
      cyc();
      n++;
    end
    while (green == 4'b0000 && n < 2000) begin
      cyc();
      n++;
    end
    g  = green;
    to = (n >= 2000);
  endtask

  task automatic test_reset();
    tick    = 1'b1;
    ur_list = 4'b0000;
    do_reset();
    checks++;
    if (all_red !== 1'b1 || green !== 4'b0000 || yellow !== 4'b0000
        || active_dir !== 2'd3) begin
      failures++;
      $display("FAIL reset: ar=%b g=%b y=%b dir=%0d want ar=1 g=0 y=0 dir=3",
               all_red, green, yellow, active_dir);
    end
  endtask

  task automatic test_basic();
    logic [3:0] eg, ey;
    logic       ea;
    ur_list = 4'b0000;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      eg = 4'b0000;
      ey = 4'b0000;
      if (i >= 2 && i <= 6) eg = 4'b0001;
      if (i >= 7 && i <= 9) ey = 4'b0001;
      if (i == 12) eg = 4'b0010;
      ea = (eg == 4'b0000) && (ey == 4'b0000);
      checks++;
      if (green !== eg || yellow !== ey || all_red !== ea) begin
        failures++;
        $display("FAIL basic c%0d: g=%b y=%b ar=%b want g=%b y=%b ar=%b",
                 i, green, yellow, all_red, eg, ey, ea);
      end
      cyc();
    end
  endtask

  task automatic test_skip();
    logic [3:0] g;
    logic [3:0] exp_g[4];
    bit to;
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b1000;
    exp_g[2] = 4'b0001;
    exp_g[3] = 4'b1000;
    ur_list = 4'b0110;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_green(g, to);
      checks++;
      if (to || g !== exp_g[k]) begin
        failures++;
        $display("FAIL skip #%0d: green=%b timeout=%0d want %b",
                 k, g, to, exp_g[k]);
      end
    end
    checks++;
    if (seen[2:1] !== 2'b00) begin
      failures++;
      $display("FAIL skip_bc: seen=%b want bits1,2 zero", seen);
    end
  endtask

  task automatic test_extend();
    logic [3:0] g, eg, ey;
    bit to;
    bit bad;
    ur_list = 4'b0000;
    do_reset();
    next_green(g, to);
    ur_list = 4'b1110;
    bad = to || (g !== 4'b0001);
    for (int i = 0; i < 15; i++) begin
      if (green !== 4'b0001 || yellow !== 4'b0000) bad = 1'b1;
      cyc();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL extend: g=%b y=%b want A green held",
               green, yellow);
    end
    ur_list = 4'b0000;
    for (int i = 0; i < 11; i++) begin
      eg = 4'b0000;
      ey = 4'b0000;
      if (i <= 4) eg = 4'b0001;
      if (i >= 5 && i <= 7) ey = 4'b0001;
      if (i == 10) eg = 4'b0010;
      checks++;
      if (green !== eg || yellow !== ey) begin
        failures++;
        $display("FAIL extend_end c%0d: g=%b y=%b want g=%b y=%b",
                 i, green, yellow, eg, ey);
      end
      cyc();
    end
  endtask

  task automatic test_rotate();
    logic [3:0] g, eg;
    bit to;
    ur_list = 4'b1111;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      next_green(g, to);
      eg = 4'b0001 << (k % 4);
      checks++;
      if (to || g !== eg) begin
        failures++;
        $display("FAIL rotate #%0d: green=%b timeout=%0d want %b",
                 k, g, to, eg);
      end
    end
  endtask

  task automatic test_srst_mid();
    logic [3:0] g;
    bit to;
    ur_list = 4'b1111;
    do_reset();
    for (int k = 0; k < 3; k++) next_green(g, to);
    cyc();
    cyc();
    checks++;
    if (to || green !== 4'b0100) begin
      failures++;
      $display("FAIL srst_pre: green=%b timeout=%0d want 0100", green, to);
    end
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    checks++;
    if (all_red !== 1'b1 || green !== 4'b0000 || yellow !== 4'b0000
        || active_dir !== 2'd3) begin
      failures++;
      $display("FAIL srst_mid: ar=%b g=%b y=%b dir=%0d want ar=1 g=0 y=0 dir=3",
               all_red, green, yellow, active_dir);
    end
    ur_list = 4'b0000;
    next_green(g, to);
    checks++;
    if (to || g !== 4'b0001) begin
      failures++;
      $display("FAIL srst_next: green=%b timeout=%0d want 0001", g, to);
    end
  endtask

  task automatic test_tick_hold();
    logic [3:0] g, eg, ey;
    bit to;
    bit bad;
    ur_list = 4'b0000;
    do_reset();
    next_green(g, to);
    cyc();
    cyc();
    tick = 1'b0;
    bad = to;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (green !== 4'b0001 || yellow !== 4'b0000 || all_red !== 1'b0
          || active_dir !== 2'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold: g=%b y=%b ar=%b dir=%0d want frozen A green",
               green, yellow, all_red, active_dir);
    end
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eg = (i < 3) ? 4'b0001 : 4'b0000;
      ey = (i == 3) ? 4'b0001 : 4'b0000;
      checks++;
      if (green !== eg || yellow !== ey) begin
        failures++;
        $display("FAIL resume c%0d: g=%b y=%b want g=%b y=%b",
                 i, green, yellow, eg, ey);
      end
      cyc();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    seen     = 4'b0000;
    srst     = 1'b0;
    tick     = 1'b1;
    ur_list  = 4'b0000;
    test_reset();
    test_basic();
    test_skip();
    test_extend();
    test_rotate();
    test_srst_mid();
    test_tick_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
